// File: rtl/imu_event_scheduler_if.sv
// Valid/ready bus between the per-axis IMU sample sources, the shared threshold
// comparator, and downstream event logging.
interface imu_event_scheduler_if #(
    parameter int unsigned WIDTH = 16
);
    logic [2:0]         in_valid;
    logic [2:0]         in_ready;
    logic [3*WIDTH-1:0] in_data;
    logic [3*WIDTH-1:0] thr;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_axis;
    logic [WIDTH-1:0]   out_sample;
    logic               out_event;

    modport master (
        output in_valid, in_data, thr, out_ready,
        input  in_ready, out_valid, out_axis, out_sample, out_event
    );

    modport slave (
        input  in_valid, in_data, thr, out_ready,
        output in_ready, out_valid, out_axis, out_sample, out_event
    );
endinterface

// File: rtl/imu_event_scheduler.sv
// Round-robin scheduler sharing one registered threshold comparator among X/Y/Z streams.
// Optional per-axis event counters are enabled by defining IMU_SCHED_EVTCNT_EN.
module imu_event_scheduler #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    imu_event_scheduler_if.slave bus
`ifdef IMU_SCHED_EVTCNT_EN
    ,
    input  logic               clr_cnt,
    output logic [3*CNT_W-1:0] evt_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_OUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       last;
    logic [1:0]       first;
    logic [1:0]       second;
    logic [1:0]       third;
    logic [1:0]       sel;
    logic             grant;
    logic [1:0]       axis_q;
    logic [WIDTH-1:0] sample_q;
    logic [WIDTH-1:0] thr_q;
    logic             event_q;
    logic             valid_q;

    // Search order starts one past the most recently served axis
    always_comb begin
        first  = (last   == 2'd2) ? 2'd0 : last   + 2'd1;
        second = (first  == 2'd2) ? 2'd0 : first  + 2'd1;
        third  = (second == 2'd2) ? 2'd0 : second + 2'd1;
        if (bus.in_valid[first]) begin
            sel = first;
        end else if (bus.in_valid[second]) begin
            sel = second;
        end else begin
            sel = third;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        grant        = 1'b0;
        bus.in_ready = '0;
        case (state)
            S_IDLE: begin
                if (enable && (|bus.in_valid)) begin
                    grant             = 1'b1;
                    bus.in_ready[sel] = 1'b1;
                    state_next        = S_CMP;
                end
            end
            S_CMP: state_next = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 2'd2;
            axis_q   <= '0;
            sample_q <= '0;
            thr_q    <= '0;
            event_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        axis_q   <= sel;
                        sample_q <= bus.in_data[int'(sel)*WIDTH +: WIDTH];
                        thr_q    <= bus.thr[int'(sel)*WIDTH +: WIDTH];
                    end
                end
                S_CMP: begin
                    event_q <= (sample_q > thr_q);
                    valid_q <= 1'b1;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last    <= axis_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_axis   = axis_q;
    assign bus.out_sample = sample_q;
    assign bus.out_event  = event_q;

`ifdef IMU_SCHED_EVTCNT_EN
    logic [CNT_W-1:0] cnt [3];

    // Clear takes priority over an increment landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else if (clr_cnt) begin
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else if (valid_q && bus.out_ready && event_q && (cnt[axis_q] != '1)) begin
            cnt[axis_q] <= cnt[axis_q] + 1'b1;
        end
    end

    always_comb begin
        evt_cnt = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            evt_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_imu_event_scheduler.sv
// Randomized and directed bench for imu_event_scheduler against a transaction-level
// reference model; counter checks apply when IMU_SCHED_EVTCNT_EN is defined.
module tb_imu_event_scheduler;

    localparam int unsigned WIDTH = 16;
`ifdef IMU_SCHED_EVTCNT_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 8;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
`ifdef IMU_SCHED_EVTCNT_EN
    logic               clr_cnt;
    logic [3*CNT_W-1:0] evt_cnt;
`endif

    imu_event_scheduler_if #(.WIDTH(WIDTH)) bus_if ();

    imu_event_scheduler #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus_if)
`ifdef IMU_SCHED_EVTCNT_EN
        ,
        .clr_cnt(clr_cnt),
        .evt_cnt(evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, result visible two cycles after grant
    bit               m_busy;
    int unsigned      m_last;
    longint           m_valid_at;
    int unsigned      m_axis;
    logic [WIDTH-1:0] m_sample;
    bit               m_event;
    int unsigned      m_cnt [3];
    longint           cycle = 0;
    logic [2:0]       grants [$];

    function automatic int unsigned pick(input logic [2:0] v);
        for (int unsigned k = 1; k <= 3; k++) begin
            if (v[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        m_last = 2;
        for (int unsigned i = 0; i < 3; i++) m_cnt[i] = 0;
    endfunction

    task automatic step(input logic [2:0] v, input logic en, input logic ordy, input logic clr,
                        input logic [3*WIDTH-1:0] data, input logic [3*WIDTH-1:0] thr_v);
        logic [2:0]  exp_ready;
        bit          exp_valid;
        int unsigned a;
        @(negedge clk);
        bus_if.in_valid  = v;
        enable           = en;
        bus_if.out_ready = ordy;
        bus_if.in_data   = data;
        bus_if.thr       = thr_v;
`ifdef IMU_SCHED_EVTCNT_EN
        clr_cnt = clr;
`endif
        #1;
        exp_ready = '0;
        if (!m_busy && en && (|v)) exp_ready[pick(v)] = 1'b1;
        check_eq("in_ready", 64'(bus_if.in_ready), 64'(exp_ready));
        if (bus_if.in_ready != 3'b000) grants.push_back(bus_if.in_ready);
        exp_valid = m_busy && (cycle >= m_valid_at);
        check_eq("out_valid", 64'(bus_if.out_valid), 64'(exp_valid));
        if (exp_valid) begin
            check_eq("out_axis", 64'(bus_if.out_axis), 64'(m_axis));
            check_eq("out_sample", 64'(bus_if.out_sample), 64'(m_sample));
            check_eq("out_event", 64'(bus_if.out_event), 64'(m_event));
        end
`ifdef IMU_SCHED_EVTCNT_EN
        for (int unsigned i = 0; i < 3; i++) begin
            check_eq("evt_cnt", 64'(evt_cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
        end
`endif
        if (exp_valid && ordy) begin
            m_busy = 1'b0;
            m_last = m_axis;
            if (m_event && m_cnt[m_axis] < (2 ** CNT_W) - 1) m_cnt[m_axis]++;
        end else if (exp_ready != 3'b000) begin
            a          = pick(v);
            m_axis     = a;
            m_sample   = data[a*WIDTH +: WIDTH];
            m_event    = data[a*WIDTH +: WIDTH] > thr_v[a*WIDTH +: WIDTH];
            m_busy     = 1'b1;
            m_valid_at = cycle + 2;
        end
        if (clr) begin
            for (int unsigned i = 0; i < 3; i++) m_cnt[i] = 0;
        end
        cycle++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus_if.in_valid = '0;
        #1;
        check_eq("rst_in_ready", 64'(bus_if.in_ready), 64'(0));
        check_eq("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
        check_eq("rst_out_axis", 64'(bus_if.out_axis), 64'(0));
        check_eq("rst_out_sample", 64'(bus_if.out_sample), 64'(0));
        check_eq("rst_out_event", 64'(bus_if.out_event), 64'(0));
`ifdef IMU_SCHED_EVTCNT_EN
        check_eq("rst_evt_cnt", 64'(evt_cnt), 64'(0));
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom % 6)
            0:       return '0;
            1:       return '1;
            2:       return {{(WIDTH-1){1'b1}}, 1'b0};
            3:       return WIDTH'(100);
            4:       return WIDTH'(101);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    logic [3*WIDTH-1:0] d;
    logic [3*WIDTH-1:0] t;
    logic [WIDTH-1:0]   bs [4];
    logic [WIDTH-1:0]   bt [4];

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b0;
        bus_if.in_valid  = '0;
        bus_if.in_data   = '0;
        bus_if.thr       = '0;
        bus_if.out_ready = 1'b0;
`ifdef IMU_SCHED_EVTCNT_EN
        clr_cnt = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Single sample on axis 0 above threshold
        t = {3{WIDTH'(100)}};
        d = {WIDTH'(0), WIDTH'(0), WIDTH'(150)};
        step(3'b001, 1'b1, 1'b1, 1'b0, d, t);
        repeat (4) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);

        // All axes requesting: grants rotate 0,1,2,0 from reset
        do_reset();
        grants.delete();
        d = {WIDTH'(101), WIDTH'(100), WIDTH'(50)};
        repeat (12) step(3'b111, 1'b1, 1'b1, 1'b0, d, t);
        check_eq("grant_count", 64'(grants.size()), 64'(4));
        if (grants.size() >= 4) begin
            check_eq("grant0", 64'(grants[0]), 64'(3'b001));
            check_eq("grant1", 64'(grants[1]), 64'(3'b010));
            check_eq("grant2", 64'(grants[2]), 64'(3'b100));
            check_eq("grant3", 64'(grants[3]), 64'(3'b001));
        end
        repeat (3) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);

        // Downstream stall holds the result and blocks new grants
        step(3'b010, 1'b1, 1'b0, 1'b0, d, t);
        repeat (7) step(3'b111, 1'b1, 1'b0, 1'b0, d, t);
        repeat (4) step(3'b111, 1'b1, 1'b1, 1'b0, d, t);
        repeat (3) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);

        // Disable during compare: result completes, no new grant
        step(3'b001, 1'b1, 1'b1, 1'b0, d, t);
        repeat (6) step(3'b111, 1'b0, 1'b1, 1'b0, d, t);
        repeat (4) step(3'b111, 1'b1, 1'b1, 1'b0, d, t);
        repeat (3) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);

        // Reset while a result waits downstream
        step(3'b100, 1'b1, 1'b0, 1'b0, d, t);
        repeat (3) step(3'b000, 1'b1, 1'b0, 1'b0, d, t);
        do_reset();
        step(3'b111, 1'b1, 1'b1, 1'b0, d, t);
        check_eq("post_reset_grant", 64'(bus_if.in_ready), 64'(3'b001));
        repeat (3) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);

        // Comparator boundaries
        bs[0] = WIDTH'(5);  bt[0] = WIDTH'(5);
        bs[1] = '0;         bt[1] = '0;
        bs[2] = '1;         bt[2] = {{(WIDTH-1){1'b1}}, 1'b0};
        bt[3] = '1;         bs[3] = {{(WIDTH-1){1'b1}}, 1'b0};
        for (int i = 0; i < 4; i++) begin
            d = {3{bs[i]}};
            t = {3{bt[i]}};
            step(3'b001, 1'b1, 1'b1, 1'b0, d, t);
            repeat (2) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);
            check_eq("boundary_event", 64'(bus_if.out_event), 64'(i == 2));
            step(3'b000, 1'b1, 1'b1, 1'b0, d, t);
        end

`ifdef IMU_SCHED_EVTCNT_EN
        // Axis 1 saturation, then clear against a same-cycle event
        do_reset();
        d = {WIDTH'(0), WIDTH'(200), WIDTH'(0)};
        t = {3{WIDTH'(100)}};
        for (int i = 0; i < 5; i++) begin
            step(3'b010, 1'b1, 1'b1, 1'b0, d, t);
            repeat (2) step(3'b000, 1'b1, 1'b1, 1'b0, d, t);
        end
        step(3'b000, 1'b1, 1'b1, 1'b0, d, t);
        check_eq("evt_cnt_sat", 64'(evt_cnt[CNT_W +: CNT_W]), 64'(3));
        step(3'b010, 1'b1, 1'b1, 1'b0, d, t);
        step(3'b000, 1'b1, 1'b1, 1'b0, d, t);
        step(3'b000, 1'b1, 1'b1, 1'b1, d, t);
        step(3'b000, 1'b1, 1'b1, 1'b0, d, t);
        check_eq("evt_cnt_clr", 64'(evt_cnt[CNT_W +: CNT_W]), 64'(0));
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int a = 0; a < 3; a++) begin
                d[a*WIDTH +: WIDTH] = rand_word();
                t[a*WIDTH +: WIDTH] = rand_word();
            end
            step(3'($urandom), ($urandom % 8) != 0, ($urandom % 4) != 0,
                 ($urandom % 40) == 0, d, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
